// File: rtl/fetch_boot_ctrl.sv
// Boot sequencer: holds the SoC core in reset, then gates fetch_enable until the fetch switch is
// on and the SPI loader has been quiet. Optional heartbeat watchdog under FETCH_BOOT_WDT_EN.
module fetch_boot_ctrl #(
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned QUIET_CYCLES = 1024,
  parameter int unsigned WDT_CYCLES   = 16777215
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_sw_i,
  input  logic       spi_cs_i,
  input  logic       heartbeat_i,
  output logic       core_rst_n_o,
  output logic       fetch_enable_o,
  output logic [1:0] state_o,
  output logic       wdt_trip_o
);

  typedef enum logic [1:0] {
    StHold  = 2'd0,
    StIdle  = 2'd1,
    StQuiet = 2'd2,
    StRun   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RstLast   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] QuietLast = CNT_W'(QUIET_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sw_meta_q, sw_s;
  logic             cs_meta_q, cs_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_q <= 1'b0;
      sw_s      <= 1'b0;
      cs_meta_q <= 1'b1;
      cs_s      <= 1'b1;
    end else begin
      sw_meta_q <= fetch_sw_i;
      sw_s      <= sw_meta_q;
      cs_meta_q <= spi_cs_i;
      cs_s      <= cs_meta_q;
    end
  end

`ifdef FETCH_BOOT_WDT_EN
  localparam logic [CNT_W-1:0] WdtLast = CNT_W'(WDT_CYCLES - 1);

  logic hb_meta_q, hb_s, hb_q;
  logic hb_edge;
  logic wdt_trip_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_meta_q <= 1'b0;
      hb_s      <= 1'b0;
      hb_q      <= 1'b0;
    end else begin
      hb_meta_q <= heartbeat_i;
      hb_s      <= hb_meta_q;
      hb_q      <= hb_s;
    end
  end

  assign hb_edge    = hb_s ^ hb_q;
  assign wdt_trip_o = wdt_trip_q;
`else
  logic unused_heartbeat;
  assign unused_heartbeat = heartbeat_i;
  assign wdt_trip_o       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StHold;
      cnt_q      <= '0;
`ifdef FETCH_BOOT_WDT_EN
      wdt_trip_q <= 1'b0;
`endif
    end else begin
`ifdef FETCH_BOOT_WDT_EN
      wdt_trip_q <= 1'b0;
`endif
      unique case (state_q)
        StHold: begin
          if (cnt_q == RstLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StIdle: begin
          if (sw_s && cs_s) begin
            state_q <= StQuiet;
            cnt_q   <= '0;
          end
        end
        StQuiet: begin
          if (!sw_s) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (!cs_s) begin
            // Loader still active: restart the full quiet period.
            cnt_q <= '0;
          end else if (cnt_q == QuietLast) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
`ifdef FETCH_BOOT_WDT_EN
          // A heartbeat edge rescues an expiring count; expiry beats the switch.
          if (!hb_edge && cnt_q == WdtLast) begin
            state_q    <= StHold;
            cnt_q      <= '0;
            wdt_trip_q <= 1'b1;
          end else if (!sw_s) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (hb_edge) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`else
          if (!sw_s) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
`endif
        end
        default: begin
          state_q <= StHold;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign core_rst_n_o   = (state_q != StHold);
  assign fetch_enable_o = (state_q == StRun);
  assign state_o        = state_q;

endmodule

// File: tb/tb_fetch_boot_ctrl.sv
// Directed bench for fetch_boot_ctrl: reset release, quiet-period gating, SPI restart, switch
// drop, mid-QUIET reset and (with FETCH_BOOT_WDT_EN) the heartbeat watchdog.
module tb_fetch_boot_ctrl;

  logic       clk;
  logic       rst_n;
  logic       fetch_sw_i;
  logic       spi_cs_i;
  logic       heartbeat_i;
  logic       core_rst_n_o;
  logic       fetch_enable_o;
  logic [1:0] state_o;
  logic       wdt_trip_o;

  int vectors;
  int miscompares;

  fetch_boot_ctrl #(
    .CNT_W       (24),
    .RST_CYCLES  (16),
    .QUIET_CYCLES(8),
    .WDT_CYCLES  (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_sw_i    (fetch_sw_i),
    .spi_cs_i      (spi_cs_i),
    .heartbeat_i   (heartbeat_i),
    .core_rst_n_o  (core_rst_n_o),
    .fetch_enable_o(fetch_enable_o),
    .state_o       (state_o),
    .wdt_trip_o    (wdt_trip_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    fetch_sw_i  = 1'b0;
    spi_cs_i    = 1'b1;
    heartbeat_i = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({core_rst_n_o, fetch_enable_o, state_o, wdt_trip_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rst_n=%b fe=%b st=%0d trip=%b, want all 0",
               core_rst_n_o, fetch_enable_o, state_o, wdt_trip_o);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      vectors++;
      if (core_rst_n_o !== (i >= 16) || state_o !== ((i >= 16) ? 2'd1 : 2'd0)) begin
        miscompares++;
        $display("FAIL reset_release edge %0d: got core_rst_n=%b state=%0d, want %b/%0d",
                 i, core_rst_n_o, state_o, (i >= 16), (i >= 16) ? 1 : 0);
      end
    end
  endtask

  task automatic test_fetch_start();
    logic [1:0] exp_st;
    fetch_sw_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_st = (i <= 2) ? 2'd1 : (i <= 10) ? 2'd2 : 2'd3;
      vectors++;
      if (state_o !== exp_st || fetch_enable_o !== (i >= 11) || core_rst_n_o !== 1'b1) begin
        miscompares++;
        $display("FAIL fetch_start edge %0d: got state=%0d fe=%b rst=%b, want %0d/%b/1",
                 i, state_o, fetch_enable_o, core_rst_n_o, exp_st, (i >= 11));
      end
    end
  endtask

  task automatic test_sw_drop();
    fetch_sw_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (fetch_enable_o !== (i < 3) || core_rst_n_o !== 1'b1 ||
          state_o !== ((i < 3) ? 2'd3 : 2'd1)) begin
        miscompares++;
        $display("FAIL sw_drop edge %0d: got fe=%b rst=%b state=%0d, want %b/1/%0d",
                 i, fetch_enable_o, core_rst_n_o, state_o, (i < 3), (i < 3) ? 3 : 1);
      end
    end
  endtask

  // cs low sampled at edges 9..11 -> cs_s low after 10..12, high after 13 -> RUN at edge 21.
  task automatic test_cs_restart();
    logic [1:0] exp_st;
    fetch_sw_i = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      tick();
      if (j == 8) spi_cs_i = 1'b0;
      if (j == 11) spi_cs_i = 1'b1;
      exp_st = (j <= 2) ? 2'd1 : (j <= 20) ? 2'd2 : 2'd3;
      vectors++;
      if (state_o !== exp_st || fetch_enable_o !== (j >= 21)) begin
        miscompares++;
        $display("FAIL cs_restart edge %0d: got state=%0d fe=%b, want %0d/%b",
                 j, state_o, fetch_enable_o, exp_st, (j >= 21));
      end
    end
  endtask

  task automatic test_rst_mid_quiet();
    logic [1:0] exp_st;
    fetch_sw_i = 1'b1;
    repeat (5) tick();
    vectors++;
    if (state_o !== 2'd2) begin
      miscompares++;
      $display("FAIL rst_pre_quiet: got state=%0d, want 2", state_o);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (state_o !== 2'd0 || core_rst_n_o !== 1'b0 || fetch_enable_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: got state=%0d rst=%b fe=%b, want 0/0/0",
               state_o, core_rst_n_o, fetch_enable_o);
    end
    // Full 16-cycle hold proves the counter restarted from 0.
    for (int i = 1; i <= 25; i++) begin
      tick();
      exp_st = (i <= 15) ? 2'd0 : (i == 16) ? 2'd1 : (i <= 24) ? 2'd2 : 2'd3;
      vectors++;
      if (state_o !== exp_st || core_rst_n_o !== (i >= 16)) begin
        miscompares++;
        $display("FAIL rst_recover edge %0d: got state=%0d rst=%b, want %0d/%b",
                 i, state_o, core_rst_n_o, exp_st, (i >= 16));
      end
    end
  endtask

`ifdef FETCH_BOOT_WDT_EN
  task automatic test_wdt();
    logic [1:0] exp_st;
    for (int i = 1; i <= 300; i++) begin
      if (i % 50 == 0) heartbeat_i = ~heartbeat_i;
      tick();
      vectors++;
      if (state_o !== 2'd3 || wdt_trip_o !== 1'b0) begin
        miscompares++;
        $display("FAIL wdt_alive cycle %0d: got state=%0d trip=%b, want 3/0",
                 i, state_o, wdt_trip_o);
      end
    end
    // Last heartbeat clears the count at k=2; expiry at k=102.
    for (int k = 1; k <= 127; k++) begin
      tick();
      exp_st = (k <= 101) ? 2'd3 : (k <= 117) ? 2'd0 : (k == 118) ? 2'd1 :
               (k <= 126) ? 2'd2 : 2'd3;
      vectors++;
      if (state_o !== exp_st || wdt_trip_o !== (k == 102) ||
          core_rst_n_o !== (exp_st != 2'd0)) begin
        miscompares++;
        $display("FAIL wdt_expire k=%0d: got state=%0d trip=%b rst=%b, want %0d/%b/%b",
                 k, state_o, wdt_trip_o, core_rst_n_o, exp_st, (k == 102), (exp_st != 2'd0));
      end
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fetch_start();
    test_sw_drop();
    test_cs_restart();
    test_sw_drop();
    test_rst_mid_quiet();
`ifdef FETCH_BOOT_WDT_EN
    test_wdt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_boot_ctrl.md
# fetch_boot_ctrl

Boot sequencer placed in the FPGA top level, beside the PULPino SoC instance. It holds the core in reset after board reset. It then gates `fetch_enable` so that instruction fetch only starts once the fetch switch is on and the SPI slave loader has been idle for a programmable quiet period. An optional heartbeat watchdog re-resets the core if the running program stops toggling a GPIO.

## Interface
Parameters:
- `CNT_W`, 24: width of the shared cycle counter.
- `RST_CYCLES`, 16: length of the core reset pulse in cycles; must be 1..2^CNT_W.
- `QUIET_CYCLES`, 1024: number of SPI-idle cycles required before fetch starts; must be 1..2^CNT_W.
- `WDT_CYCLES`, 16777215: heartbeat timeout in cycles; must be 1..2^CNT_W.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `fetch_sw_i`  in  1  fetch-enable switch; asynchronous.
- `spi_cs_i`  in  1  SPI slave chip select; asynchronous, active-low.
- `heartbeat_i`  in  1  GPIO output bit driven by software; asynchronous.
- `core_rst_n_o`  out  1  reset to the SoC; active-low.
- `fetch_enable_o`  out  1  fetch enable to the SoC.
- `state_o`  out  2  current state encoding, for debug LEDs.
- `wdt_trip_o`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Synchronisers: two-flop synchronisers on `fetch_sw_i`, `spi_cs_i` and `heartbeat_i`, producing `sw_s`, `cs_s` and `hb_s`.
  - Reset values: `sw_s`=0, `cs_s`=1, `hb_s`=0.
  - A third flop on `hb_s` provides edge detection; either edge counts as a heartbeat.
- Counter: one `CNT_W`-bit counter, cleared on every state transition.
- State encodings: HOLD=0, IDLE=1, QUIET=2, RUN=3.
- Output decode from the state register:
  - `core_rst_n_o` = (state != HOLD).
  - `fetch_enable_o` = (state == RUN).
  - `state_o` = state.
- HOLD:
  - If cnt == RST_CYCLES-1 → IDLE; otherwise cnt++.
- IDLE:
  - If `sw_s` & `cs_s` → QUIET.
- QUIET (checks in priority order):
  - `!sw_s` → IDLE.
  - `!cs_s` → cnt cleared; stay in QUIET (SPI loading still active).
  - cnt == QUIET_CYCLES-1 → RUN.
  - Otherwise cnt++.
- RUN:
  - `!sw_s` → IDLE. Fetch drops; the core is not reset.
  - SPI activity is ignored.
- Reset values (while `rst_n` is sampled low):
  - state = HOLD, cnt = 0.
  - `core_rst_n_o`=0, `fetch_enable_o`=0, `state_o`=0, `wdt_trip_o`=0.
  - An `rst_n` assertion mid-RUN or mid-QUIET returns to HOLD at the same edge.

## Timing
- `core_rst_n_o` is low for exactly RST_CYCLES cycles after the first edge that samples `rst_n` high.
- With the block in IDLE and `spi_cs_i` high: if edge 1 is the first edge sampling `fetch_sw_i` high, `fetch_enable_o` rises after edge QUIET_CYCLES+3. That is 2 synchroniser edges, 1 edge for IDLE→QUIET, and QUIET_CYCLES edges in QUIET.
- A `spi_cs_i` low pulse of ≥1 cycle (after synchronisation) during QUIET restarts the full quiet count.
- Dropping `fetch_sw_i` in RUN deasserts `fetch_enable_o` 3 edges after it is first sampled low.
- All outputs are glitch-free: they are decoded from registers only, with no combinational path from the inputs.

## Configuration
- Macro `FETCH_BOOT_WDT_EN`.
- Defined:
  - In RUN, a detected heartbeat edge clears cnt.
  - Otherwise, when cnt == WDT_CYCLES-1 → HOLD, and `wdt_trip_o` pulses high for the first HOLD cycle. Otherwise cnt++.
  - Watchdog expiry has priority over `!sw_s` in the same cycle.
  - The counter is cleared on entry to RUN.
- Undefined:
  - `heartbeat_i` is unused; its synchroniser is not built.
  - `wdt_trip_o` is tied to 0.
  - RUN exits only on `!sw_s`.

## Test plan
- Reset release, RST_CYCLES=16 → `core_rst_n_o` low for exactly 16 cycles after the first edge with `rst_n` sampled high; `state_o` goes 0→1.
- QUIET_CYCLES=8, `spi_cs_i`=1, `fetch_sw_i` raised → `fetch_enable_o` rises after edge 11; `state_o` goes 1→2→3.
- Same as above, with a 3-cycle `spi_cs_i` low pulse 5 cycles into QUIET → `fetch_enable_o` rises 8 cycles after `cs_s` returns high.
- In RUN, `fetch_sw_i` dropped → `fetch_enable_o` falls 3 edges later; `core_rst_n_o` stays 1; `state_o`=1.
- `FETCH_BOOT_WDT_EN` defined, WDT_CYCLES=100:
  - Heartbeat toggled every 50 cycles → remains in RUN.
  - Heartbeat stopped → after 100 cycles, a 1-cycle `wdt_trip_o` pulse, `core_rst_n_o` low for RST_CYCLES, then back through IDLE/QUIET to RUN.
- `rst_n` pulsed low for 1 cycle mid-QUIET → next edge gives state HOLD, `core_rst_n_o`=0, `fetch_enable_o`=0, cnt=0.
